// File: rtl/ssd_pkg.sv
// Shared types and segment constants for the seven-segment scan controller.
// Segment order is {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/ssd_bcd_decoder.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Non-decimal nibbles (A-F) show a dash so bad data is visible on the display.
module ssd_bcd_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment scanner with per-slot dead time and frame-boundary double buffering.
// Define LZ_BLANK_EN to suppress leading zeros on digits above digit 0.
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 65536,
    parameter int BLANK    = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  frame_tick
);

    localparam int TIMER_W = $clog2(PRESCALE);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK - 1);
    localparam logic [TIMER_W-1:0] DRIVE_LAST = TIMER_W'(PRESCALE - BLANK - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    state_t                state;
    logic [TIMER_W-1:0]    timer;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   active;
    logic [4*DIGITS-1:0]   pending;
    logic                  pending_valid;

    logic [4*DIGITS-1:0]   shifted;
    logic [6:0]            dec_seg;
    logic                  lz_blank;
    logic [DIGITS-1:0]     drive_an;
    logic [6:0]            drive_seg;

    // Nibble idx lands at the bottom; the rest of shifted holds only the higher digits.
    assign shifted = active >> {idx, 2'b00};

    ssd_bcd_decoder u_decoder (
        .bcd (shifted[3:0]),
        .seg (dec_seg)
    );

`ifdef LZ_BLANK_EN
    assign lz_blank = (idx != '0) && (shifted == '0);
`else
    assign lz_blank = 1'b0;
`endif

    assign drive_an   = lz_blank ? '1 : ~(DIGITS'(1) << idx);
    assign drive_seg  = lz_blank ? SEG_OFF : dec_seg;
    assign load_ready = !pending_valid;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            timer         <= '0;
            idx           <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            an            <= '1;
            seg           <= SEG_OFF;
            frame_tick    <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            // Accept only when empty; transfers need a pending value, so the two never collide.
            if (load_valid && !pending_valid) begin
                pending       <= load_bcd;
                pending_valid <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    an    <= '1;
                    seg   <= SEG_OFF;
                    idx   <= '0;
                    timer <= '0;
                    if (pending_valid) begin
                        active        <= pending;
                        pending_valid <= 1'b0;
                    end
                    if (enable) state <= ST_BLANK;
                end
                ST_BLANK: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        timer <= '0;
                    end else if (timer == BLANK_LAST) begin
                        state      <= ST_DRIVE;
                        timer      <= '0;
                        an         <= drive_an;
                        seg        <= drive_seg;
                        frame_tick <= (idx == IDX_LAST) && (DRIVE_LAST == '0);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        an    <= '1;
                        seg   <= SEG_OFF;
                        idx   <= '0;
                        timer <= '0;
                    end else if (timer == DRIVE_LAST) begin
                        state <= ST_BLANK;
                        timer <= '0;
                        an    <= '1;
                        seg   <= SEG_OFF;
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (pending_valid) begin
                                active        <= pending;
                                pending_valid <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        timer      <= timer + 1'b1;
                        frame_tick <= (idx == IDX_LAST) && ((timer + 1'b1) == DRIVE_LAST);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    an    <= '1;
                    seg   <= SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller: directed scenarios then random traffic, checked against a time-based display model.
// Honours LZ_BLANK_EN in the same way as the design build.
module tb_ssd_scan_controller;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = PRESCALE * DIGITS;

    logic                clock;
    logic                reset_n;
    logic                enable;
    logic                load_valid;
    logic                load_ready;
    logic [4*DIGITS-1:0] load_bcd;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                frame_tick;

    int total;
    int bad;

    // Reference state: running flag, cycles since the scan started, shown value, offered-value queue.
    bit                  m_run;
    int                  m_t;
    logic [4*DIGITS-1:0] m_active;
    logic [4*DIGITS-1:0] exp_q[$];
    logic [6:0]          lit [10];

    ssd_scan_controller #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_bcd   (load_bcd),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare after the edge.
    task automatic step();
        bit                  acc;
        int                  phase;
        int                  digit;
        logic [4*DIGITS-1:0] upper;
        logic [3:0]          nib;
        bit                  dark;
        logic [DIGITS-1:0]   exp_an;
        logic [6:0]          exp_seg;
        bit                  exp_tick;
        @(posedge clock);
        if (!reset_n) begin
            m_run    = 1'b0;
            m_t      = 0;
            m_active = '0;
            exp_q.delete();
        end else begin
            acc = load_valid && (exp_q.size() == 0);
            if (!m_run) begin
                if (exp_q.size() != 0) m_active = exp_q.pop_front();
                if (enable) begin
                    m_run = 1'b1;
                    m_t   = 0;
                end
            end else if (!enable) begin
                m_run = 1'b0;
                m_t   = 0;
            end else begin
                m_t++;
                if ((m_t % FRAME) == 0 && exp_q.size() != 0) m_active = exp_q.pop_front();
            end
            if (acc) exp_q.push_back(load_bcd);
        end
        #1;
        phase    = m_t % PRESCALE;
        digit    = (m_t / PRESCALE) % DIGITS;
        exp_an   = '1;
        exp_seg  = 7'h7F;
        exp_tick = 1'b0;
        if (m_run && phase >= BLANK) begin
            upper = m_active >> (4 * digit);
            nib   = upper[3:0];
            dark  = 1'b0;
`ifdef LZ_BLANK_EN
            dark = (digit > 0) && (upper == '0);
`endif
            if (!dark) begin
                exp_an[digit] = 1'b0;
                exp_seg = (nib <= 4'd9) ? ~lit[nib] : 7'b0111111;
            end
            exp_tick = (digit == DIGITS - 1) && (phase == PRESCALE - 1);
        end
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("frame_tick", 32'(frame_tick), 32'(exp_tick));
        check("load_ready", 32'(load_ready), 32'(exp_q.size() == 0));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [4*DIGITS-1:0] value);
        load_valid = 1'b1;
        load_bcd   = value;
        step();
        load_valid = 1'b0;
    endtask

    // Advance until the model is at the given digit slot and phase (bounded).
    task automatic run_until(input int digit, input int phase);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (m_run && ((m_t / PRESCALE) % DIGITS) == digit && (m_t % PRESCALE) == phase) break;
            step();
        end
    endtask

    initial begin
        // Lit-segment masks {g..a}, active-high; the display wants the complement.
        lit[0] = 7'h3F; lit[1] = 7'h06; lit[2] = 7'h5B; lit[3] = 7'h4F; lit[4] = 7'h66;
        lit[5] = 7'h6D; lit[6] = 7'h7D; lit[7] = 7'h07; lit[8] = 7'h7F; lit[9] = 7'h6F;
        total      = 0;
        bad        = 0;
        m_run      = 1'b0;
        m_t        = 0;
        m_active   = '0;
        reset_n    = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_bcd   = '0;
        run_cycles(2);
        reset_n = 1'b1;
        step();

        // Load 42 and scan two full frames.
        offer(8'h42);
        enable = 1'b1;
        run_cycles(2 * FRAME);

        // Reset held for two cycles in the middle of a drive slot, then restart.
        run_until(0, BLANK + 2);
        reset_n = 1'b0;
        run_cycles(2);
        reset_n = 1'b1;
        offer(8'h42);
        run_cycles(FRAME);

        // Load 99 while digit 0 drives; a second offer is held off until the frame boundary.
        run_until(0, BLANK + 1);
        offer(8'h99);
        load_valid = 1'b1;
        load_bcd   = 8'h17;
        run_cycles(FRAME + 3);
        load_valid = 1'b0;
        run_cycles(2 * FRAME);

        // Non-decimal upper nibble shows a dash.
        offer(8'hA3);
        run_cycles(2 * FRAME);

        // Drop enable in the middle of digit 1's drive slot, then re-enable.
        run_until(1, BLANK + 3);
        enable = 1'b0;
        run_cycles(3);
        enable = 1'b1;
        run_cycles(FRAME);

        // Leading-zero candidate.
        offer(8'h05);
        run_cycles(2 * FRAME);

        // Random traffic: offers, enable drops, occasional resets.
        for (int i = 0; i < 900; i++) begin
            reset_n    = ($urandom_range(0, 249) != 0);
            enable     = ($urandom_range(0, 39) != 0);
            load_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       load_bcd = 8'h00;
                1:       load_bcd = {4'h0, 4'($urandom_range(0, 15))};
                default: load_bcd = 8'($urandom);
            endcase
            step();
        end
        load_valid = 1'b0;
        enable     = 1'b1;
        reset_n    = 1'b1;
        run_cycles(2 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
